spr_spi_ctrl: RTL and testbench

//  Command controller between the SPI slave and the single-port RAM (SPR). Decodes 10-bit
//  SPI words into address/data operations, sequences RAM accesses, returns read data on
//  tx_data/tx_valid. Also arbitrates the one RAM port between SPI and a local host port.

---
 rtl/spr_ctrl_pkg.sv | 28 ++
 rtl/spr_arb.sv | 21 ++
 rtl/spr_spi_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_spr_spi_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spr_ctrl_pkg
// Description : Shared encodings for the SPI-to-SPR command controller:
//               SPI command codes and controller FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package spr_ctrl_pkg;

  // SPI word bits [9:8]
  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  // RAM port sequencer states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SPI_ACC   = 3'd1,
    ST_RD_WAIT   = 3'd2,
    ST_HOST_ACC  = 3'd3,
    ST_HOST_WAIT = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/spr_arb.sv
`default_nettype none
// ============================================================================
// Module      : spr_arb
// Description : Two-requester fixed-priority grant for the single RAM port.
//               The SPI side always wins; the host is granted only when the
//               SPI side is not requesting. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module spr_arb (
  input  logic req_spi,
  input  logic req_host,
  output logic gnt_spi,
  output logic gnt_host
);

  // SPI has absolute priority over the host
  assign gnt_spi  = req_spi;
  assign gnt_host = req_host & ~req_spi;

endmodule
`default_nettype wire

// File: rtl/spr_spi_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spr_spi_ctrl
// Description : Command controller between the SPI slave and the single-port
//               RAM. Decodes 10-bit SPI words, holds one pending RAM command,
//               sequences RAM accesses and shares the RAM port with a local
//               host port (SPI first).
//               Optional feature macro: SPR_AUTOINC_EN - post-increment the
//               SPI write/read address after each data command.
// Revision    : 1.0 - initial release
// ============================================================================
module spr_spi_ctrl
  import spr_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic                 host_gnt,
  output logic [7:0]           host_rdata,
  output logic                 host_rvld,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata,
  output logic                 err_ovf
);

  state_e               r_state;
  logic                 r_rx_valid_q;
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic                 r_pend_vld;
  logic                 r_pend_rd;
  logic [ADDR_SIZE-1:0] r_pend_addr;
  logic [7:0]           r_pend_wdata;
  logic                 r_acc_rd;

  cmd_e                 w_cmd;
  logic [ADDR_SIZE-1:0] w_payload_addr;
  logic                 w_rx_edge;
  logic                 w_is_data_cmd;
  logic                 w_drop;
  logic                 w_accept;
  logic                 w_gnt_spi;
  logic                 w_gnt_host;
  logic                 w_take_spi;

  // Only a rising edge of rx_valid carries a new command; the level is ignored
  assign w_rx_edge      = rx_valid & ~r_rx_valid_q;
  assign w_cmd          = cmd_e'(rx_data[9:8]);
  assign w_payload_addr = ADDR_SIZE'(rx_data[7:0] % MEM_DEPTH);
  // Data commands (01/11) need the pending slot; address commands never do
  assign w_is_data_cmd  = rx_data[8];
  assign w_drop         = w_rx_edge & w_is_data_cmd & r_pend_vld;
  assign w_accept       = w_rx_edge & ~w_drop;
  assign w_take_spi     = (r_state == ST_IDLE) & w_gnt_spi;

  spr_arb u_arb (
    .req_spi  (r_pend_vld),
    .req_host (host_req),
    .gnt_spi  (w_gnt_spi),
    .gnt_host (w_gnt_host)
  );

`ifdef SPR_AUTOINC_EN
  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    next_addr = (a == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : a + ADDR_SIZE'(1);
  endfunction
`endif

  // Edge-detect rx_valid, decode SPI words, manage address regs and the pending slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_valid_q <= 1'b0;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_pend_vld   <= 1'b0;
      r_pend_rd    <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_wdata <= '0;
      err_ovf      <= 1'b0;
    end else begin
      r_rx_valid_q <= rx_valid;
      if (w_take_spi) begin
        r_pend_vld <= 1'b0;
      end
      if (w_rx_edge) begin
        case (w_cmd)
          CMD_WR_ADDR: r_wr_addr <= w_payload_addr;
          CMD_RD_ADDR: r_rd_addr <= w_payload_addr;
          CMD_WR_DATA: begin
            if (r_pend_vld) begin
              err_ovf <= 1'b1;
            end else begin
              r_pend_vld   <= 1'b1;
              r_pend_rd    <= 1'b0;
              r_pend_addr  <= r_wr_addr;
              r_pend_wdata <= rx_data[7:0];
`ifdef SPR_AUTOINC_EN
              r_wr_addr    <= next_addr(r_wr_addr);
`endif
            end
          end
          CMD_RD_DATA: begin
            if (r_pend_vld) begin
              err_ovf <= 1'b1;
            end else begin
              r_pend_vld   <= 1'b1;
              r_pend_rd    <= 1'b1;
              r_pend_addr  <= r_rd_addr;
`ifdef SPR_AUTOINC_EN
              r_rd_addr    <= next_addr(r_rd_addr);
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  // RAM port sequencer with registered RAM, SPI-return and host outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_acc_rd   <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      host_gnt   <= 1'b0;
      host_rdata <= '0;
      host_rvld  <= 1'b0;
    end else begin
      // Strobes are single-cycle; ram_we never outlives ram_en
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      host_gnt  <= 1'b0;
      host_rvld <= 1'b0;
      // Any accepted SPI command invalidates the previous read result
      if (w_accept) begin
        tx_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_spi) begin
            ram_en    <= 1'b1;
            ram_we    <= ~r_pend_rd;
            ram_addr  <= r_pend_addr;
            ram_wdata <= r_pend_wdata;
            r_acc_rd  <= r_pend_rd;
            r_state   <= ST_SPI_ACC;
          end else if (w_gnt_host) begin
            ram_en    <= 1'b1;
            ram_we    <= host_we;
            ram_addr  <= host_addr;
            ram_wdata <= host_wdata;
            host_gnt  <= 1'b1;
            r_acc_rd  <= ~host_we;
            r_state   <= ST_HOST_ACC;
          end
        end
        ST_SPI_ACC:  r_state <= r_acc_rd ? ST_RD_WAIT : ST_IDLE;
        ST_RD_WAIT: begin
          // A returning read takes precedence over a same-cycle clear
          tx_data  <= ram_rdata;
          tx_valid <= 1'b1;
          r_state  <= ST_IDLE;
        end
        ST_HOST_ACC: r_state <= r_acc_rd ? ST_HOST_WAIT : ST_IDLE;
        ST_HOST_WAIT: begin
          host_rdata <= ram_rdata;
          host_rvld  <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spr_spi_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spr_spi_ctrl
// Description : Directed self-checking bench for spr_spi_ctrl with a
//               behavioural 1-cycle-latency RAM attached to the ram_* port.
//               Build with +define+SPR_AUTOINC_EN to exercise auto-increment.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spr_spi_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvld;
  logic       ram_en;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic       err_ovf;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [0:255];
  int         n_acc = 0;
  logic [7:0] acc_addr [0:63];
  logic       acc_we   [0:63];

  always #5 clk = ~clk;

  spr_spi_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
    .host_rvld(host_rvld),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .err_ovf(err_ovf)
  );

  // Behavioural single-port RAM, read data one cycle after the strobe
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // Log every RAM access cycle
  always @(negedge clk) begin
    if (ram_en) begin
      acc_addr[n_acc % 64] <= ram_addr;
      acc_we[n_acc % 64]   <= ram_we;
      n_acc <= n_acc + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] p);
    @(negedge clk);
    rx_data  = {c, p};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    int   n0;
    logic seen;

    // ---------------- reset state
    repeat (3) @(negedge clk);
    chk("rst_outs_a", {tx_data, tx_valid, host_gnt, host_rdata, host_rvld, ram_en, ram_we}, 32'h0);
    chk("rst_outs_b", {ram_addr, ram_wdata, err_ovf}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- 1: write 0xA5 at 0x12
    send(2'b00, 8'h12);
    @(negedge clk);
    chk("addr_cmd_no_ram", ram_en, 1'b0);
    send(2'b01, 8'hA5);
    @(negedge clk);
    chk("wr_en",    ram_en,    1'b1);
    chk("wr_we",    ram_we,    1'b1);
    chk("wr_addr",  ram_addr,  8'h12);
    chk("wr_wdata", ram_wdata, 8'hA5);
    @(negedge clk);
    chk("wr_single_cycle", {ram_en, ram_we}, 2'b00);

    // ---------------- 2: read back 0x12 over SPI
    send(2'b10, 8'h12);
    send(2'b11, 8'h00);
    @(negedge clk);
    chk("rd_en",   {ram_en, ram_we}, 2'b10);
    chk("rd_addr", ram_addr, 8'h12);
    @(negedge clk);
    chk("tx_valid_before_E3", tx_valid, 1'b0);
    @(negedge clk);
    chk("tx_valid_E3", tx_valid, 1'b1);
    chk("tx_data",     tx_data,  8'hA5);
    repeat (3) @(negedge clk);
    chk("tx_valid_hold", tx_valid, 1'b1);
    send(2'b00, 8'h20);
    chk("tx_valid_clear_on_cmd", tx_valid, 1'b0);

    // ---------------- 3: SPI write pending beats same-cycle host read
    @(negedge clk);
    rx_data  = {2'b01, 8'h3C};
    rx_valid = 1'b1;
    host_we  = 1'b0;
    host_addr = 8'h12;
    @(negedge clk);
    rx_valid = 1'b0;
    host_req = 1'b1;
    @(negedge clk);
    chk("arb_spi_first", {ram_en, ram_we, host_gnt}, 3'b110);
    chk("arb_spi_addr",  ram_addr, 8'h20);
    k = 0;
    while (!host_gnt && k < 6) begin
      @(negedge clk);
      k++;
    end
    chk("host_gnt_delay", k, 2);
    chk("host_acc", {ram_en, ram_we, ram_addr}, {2'b10, 8'h12});
    host_req = 1'b0;
    k = 0;
    while (!host_rvld && k < 6) begin
      @(negedge clk);
      k++;
    end
    chk("host_rvld_seen", (k < 6), 1'b1);
    chk("host_rdata",     host_rdata, 8'hA5);
    @(negedge clk);
    chk("host_rvld_pulse", host_rvld, 1'b0);
    chk("host_gnt_pulse",  host_gnt,  1'b0);

    // ---------------- 5a: rx_valid held high -> one command
    n0 = n_acc;
    @(negedge clk);
    rx_data  = {2'b01, 8'h77};
    rx_valid = 1'b1;
    repeat (10) @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("level_one_cmd", n_acc - n0, 1);
    chk("no_ovf_yet",    err_ovf,    1'b0);

    // ---------------- 5b: rise while pending -> dropped, err_ovf sticky
    n0 = n_acc;
    @(negedge clk); rx_data = {2'b11, 8'h00}; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    @(negedge clk); rx_data = {2'b01, 8'h44}; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    @(negedge clk); rx_data = {2'b01, 8'h55}; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("ovf_access_count", n_acc - n0, 2);
    chk("ovf_flag",         err_ovf,    1'b1);
    repeat (4) @(negedge clk);
    chk("ovf_sticky",       err_ovf,    1'b1);

    // ---------------- 4: async reset during RD_WAIT
    send(2'b10, 8'h12);
    send(2'b11, 8'h00);
    @(negedge clk);
    chk("pre_rst_in_access", ram_en, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_a", {tx_data, tx_valid, host_gnt, host_rdata, host_rvld, ram_en, ram_we}, 32'h0);
    chk("async_rst_b", {ram_addr, ram_wdata, err_ovf}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (tx_valid || host_rvld) seen = 1'b1;
    end
    chk("no_late_valid", seen, 1'b0);

    // wr_addr returns to 0 after reset
    send(2'b01, 8'h66);
    @(negedge clk);
    chk("post_rst_wr_addr", {ram_en, ram_we, ram_addr}, {2'b11, 8'h00});

    // ---------------- 6: two writes from 0xFF
    send(2'b00, 8'hFF);
    n0 = n_acc;
    send(2'b01, 8'h11);
    repeat (3) @(negedge clk);
    send(2'b01, 8'h22);
    repeat (3) @(negedge clk);
    chk("seq_count",  n_acc - n0, 2);
    chk("seq_addr0",  {acc_we[n0 % 64], acc_addr[n0 % 64]}, {1'b1, 8'hFF});
`ifdef SPR_AUTOINC_EN
    chk("seq_addr1",  {acc_we[(n0 + 1) % 64], acc_addr[(n0 + 1) % 64]}, {1'b1, 8'h00});
    chk("seq_memFF",  mem[8'hFF], 8'h11);
    chk("seq_mem00",  mem[8'h00], 8'h22);
`else
    chk("seq_addr1",  {acc_we[(n0 + 1) % 64], acc_addr[(n0 + 1) % 64]}, {1'b1, 8'hFF});
    chk("seq_memFF",  mem[8'hFF], 8'h22);
    chk("seq_mem00",  mem[8'h00], 8'h66);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
